// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch op encodings, resolver FSM states and
// the instruction alignment mask used when checking branch targets.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_FLUSH    = 2'b10
    } rs_state_t;

    // Instructions are word aligned; any set bit here makes a target illegal.
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_decide.sv
// Combinational branch decision: taken/not-taken, target = pc + imm
// (silent wrap modulo 2^WIDTH) and the misaligned-taken-target flag.
module branch_decide
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       br_op,
    input  logic             eq,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             misalign
);

    br_op_t op;

    assign op       = br_op_t'(br_op);
    assign taken    = ((op == BR_BEQ) && eq) || ((op == BR_BNE) && !eq) || (op == BR_JUMP);
    assign target   = pc + imm;
    // Only a taken branch can be misaligned; not-taken targets are never used.
    assign misalign = taken && ((target[1:0] & INSTR_ALIGN_MASK) != 2'b00);

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts a decoded branch plus comparator result, issues a
// redirect to fetch over valid/ready, then holds flush for FLUSH_CYCLES.
// Optional taken/not-taken statistics counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       br_op,
    input  logic             eq,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic             done,
    output logic             misalign
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]      stat_taken,
    output logic [31:0]      stat_not_taken,
    input  logic             stat_clear
`endif
);

    localparam int CNT_W = 4;

    rs_state_t        state;
    logic [CNT_W-1:0] flush_cnt;
    logic             dec_taken;
    logic             dec_misalign;
    logic [WIDTH-1:0] dec_target;
    logic             accept;

    branch_decide #(.WIDTH(WIDTH)) u_decide (
        .br_op    (br_op),
        .eq       (eq),
        .pc       (pc),
        .imm      (imm),
        .taken    (dec_taken),
        .target   (dec_target),
        .misalign (dec_misalign)
    );

    // in_ready is a registered copy of "state is IDLE", so it is low in reset.
    assign accept = (state == ST_IDLE) && in_valid && in_ready;

    // Resolver FSM with registered outputs and flush down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            in_ready       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            done           <= 1'b0;
            misalign       <= 1'b0;
            flush_cnt      <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (!dec_taken) begin
                            done <= 1'b1;
                        end else if (dec_misalign) begin
                            misalign <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= dec_target;
                            in_ready       <= 1'b0;
                            state          <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b1;
                        flush_cnt      <= CNT_W'(FLUSH_CYCLES - 1);
                        state          <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush    <= 1'b0;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (stat_clear) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (accept) begin
            if (dec_taken && !dec_misalign && (stat_taken != '1))
                stat_taken <= stat_taken + 1'b1;
            if (!dec_taken && (stat_not_taken != '1))
                stat_not_taken <= stat_not_taken + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed cases then randomized
// requests checked against a transaction-level reference model.
// Define BRANCH_RESOLVER_STATS_EN to also exercise the statistics counters.
module tb_branch_resolver;

    localparam int WIDTH = 32;
    localparam int FC    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       br_op = 2'b00;
    logic             eq = 1'b0;
    logic [WIDTH-1:0] pc = '0;
    logic [WIDTH-1:0] imm = '0;
    logic             redirect_valid;
    logic             redirect_ready = 1'b0;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;
    logic             done;
    logic             misalign;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
    logic        stat_clear = 1'b0;
    int          m_taken = 0;
    int          m_not   = 0;
`endif

    always #5 clk = ~clk;

    branch_resolver #(.WIDTH(WIDTH), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .br_op          (br_op),
        .eq             (eq),
        .pc             (pc),
        .imm            (imm),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .done           (done),
        .misalign       (misalign)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
        .stat_clear     (stat_clear)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One request from acceptance to retirement. Called at a negedge with the
    // resolver idle; returns at the negedge where done is expected high.
    task automatic run_txn(input logic [1:0] op, input logic e, input logic [31:0] p,
                           input logic [31:0] i, input int wait_cyc);
        logic        exp_taken;
        logic        exp_mis;
        logic [31:0] tgt;
        int          nf;
        exp_taken = (op == 2'd3) || (op == 2'd1 && e) || (op == 2'd2 && !e);
        tgt       = p + i;
        exp_mis   = exp_taken && (tgt % 4 != 0);
        n_txn++;
        $display("[TB] txn %0d op=%0d eq=%0d pc=%08h imm=%08h taken=%0d misalign=%0d wait=%0d",
                 n_txn, op, e, p, i, exp_taken, exp_mis, wait_cyc);
        check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
        br_op = op; eq = e; pc = p; imm = i; in_valid = 1'b1;
        redirect_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        br_op = 2'($urandom); eq = 1'($urandom); pc = $urandom; imm = $urandom;
        if (!exp_taken || exp_mis) begin
`ifdef BRANCH_RESOLVER_STATS_EN
            if (!exp_taken) m_not++;
            if (stat_clear) begin m_taken = 0; m_not = 0; end
`endif
            redirect_ready = 1'b0;
            check_eq("done_fast", {31'd0, done}, 32'd1);
            check_eq("misalign", {31'd0, misalign}, {31'd0, exp_mis});
            check_eq("no_redirect", {31'd0, redirect_valid}, 32'd0);
            check_eq("no_flush", {31'd0, flush}, 32'd0);
        end else begin
`ifdef BRANCH_RESOLVER_STATS_EN
            m_taken++;
            if (stat_clear) begin m_taken = 0; m_not = 0; end
`endif
            check_eq("redirect_valid", {31'd0, redirect_valid}, 32'd1);
            check_eq("redirect_pc", redirect_pc, tgt);
            check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
            check_eq("misalign_taken", {31'd0, misalign}, 32'd0);
            redirect_ready = 1'b0;
            for (int k = 0; k < wait_cyc; k++) begin
                @(negedge clk);
                check_eq("rv_hold", {31'd0, redirect_valid}, 32'd1);
                check_eq("pc_hold", redirect_pc, tgt);
                check_eq("ready_hold", {31'd0, in_ready}, 32'd0);
                check_eq("flush_early", {31'd0, flush}, 32'd0);
            end
            redirect_ready = 1'b1;
            @(negedge clk);
            redirect_ready = 1'($urandom_range(0, 1));
            check_eq("rv_drop", {31'd0, redirect_valid}, 32'd0);
            nf = 0;
            while (flush === 1'b1 && nf < 20) begin
                check_eq("ready_in_flush", {31'd0, in_ready}, 32'd0);
                nf++;
                @(negedge clk);
                redirect_ready = 1'($urandom_range(0, 1));
            end
            redirect_ready = 1'b0;
            check_eq("flush_len", nf, FC);
            check_eq("done_after_flush", {31'd0, done}, 32'd1);
            check_eq("ready_after_flush", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_pc;
        logic [31:0] r_imm;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check_eq("rst_pc", redirect_pc, 32'd0);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_mis", {31'd0, misalign}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Directed cases, back-to-back where the resolver stays idle.
        run_txn(2'd1, 1'b1, 32'h0000_0100, 32'h0000_0020, 0);
        run_txn(2'd2, 1'b1, 32'h0000_0200, 32'h0000_0040, 0);
        run_txn(2'd0, 1'b0, 32'h0000_0300, 32'h0000_0004, 0);
        run_txn(2'd3, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 5);
        run_txn(2'd1, 1'b1, 32'h0000_0100, 32'h0000_0006, 0);

        // Reset while flushing abandons everything immediately.
        br_op = 2'd3; eq = 1'b0; pc = 32'h400; imm = 32'h10; in_valid = 1'b1;
        redirect_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rstmid_rv", {31'd0, redirect_valid}, 32'd1);
        @(negedge clk);
        check_eq("rstmid_flush", {31'd0, flush}, 32'd1);
        redirect_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rstmid_flush0", {31'd0, flush}, 32'd0);
        check_eq("rstmid_rv0", {31'd0, redirect_valid}, 32'd0);
        check_eq("rstmid_done0", {31'd0, done}, 32'd0);
        check_eq("rstmid_ready0", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef BRANCH_RESOLVER_STATS_EN
        m_taken = 0; m_not = 0;
`endif
        @(negedge clk);
        check_eq("rstmid_ready1", {31'd0, in_ready}, 32'd1);
        check_eq("rstmid_flush_idle", {31'd0, flush}, 32'd0);

        // Randomized requests.
        for (int t = 0; t < 40; t++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_imm = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            run_txn(r_op, 1'($urandom_range(0, 1)), r_pc, r_imm, int'($urandom_range(0, 3)));
        end

`ifdef BRANCH_RESOLVER_STATS_EN
        check_eq("stat_taken", stat_taken, m_taken);
        check_eq("stat_not_taken", stat_not_taken, m_not);
        stat_clear = 1'b1;
        run_txn(2'd3, 1'b0, 32'h100, 32'h20, 0);
        stat_clear = 1'b0;
        check_eq("stat_clr_taken", stat_taken, 32'd0);
        check_eq("stat_clr_not", stat_not_taken, 32'd0);
        run_txn(2'd3, 1'b0, 32'h100, 32'h20, 0);
        run_txn(2'd1, 1'b1, 32'h200, 32'h40, 1);
        run_txn(2'd2, 1'b0, 32'h300, 32'h8, 0);
        run_txn(2'd0, 1'b1, 32'h400, 32'h8, 0);
        run_txn(2'd1, 1'b0, 32'h500, 32'h8, 0);
        check_eq("stat_taken3", stat_taken, 32'd3);
        check_eq("stat_not2", stat_not_taken, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
